// File: rtl/zeroriscy_xbar_nxm.sv
// rtl/zeroriscy_xbar_nxm.sv - NM x NS req/gnt/rvalid crossbar with round-robin arbitration and in-order response routing
// Unmapped addresses are answered one cycle later by an internal error responder.
`timescale 1ns/1ps
module zeroriscy_xbar_nxm #(
  parameter int NM = 2,
  parameter int NS = 3,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [NS*AW-1:0] SLV_BASE = {32'h0000_0000, 32'h8010_0000, 32'h8000_0000},
  parameter logic [NS*AW-1:0] SLV_MASK = {32'h0000_0000, 32'hFFF0_0000, 32'hFFF0_0000}
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NM-1:0]        m_req,
  input  logic [NM-1:0]        m_we,
  input  logic [NM*(DW/8)-1:0] m_be,
  input  logic [NM*AW-1:0]     m_addr,
  input  logic [NM*DW-1:0]     m_wdata,
  output logic [NM-1:0]        m_gnt,
  output logic [NM-1:0]        m_rvalid,
  output logic [NM*DW-1:0]     m_rdata,
  output logic [NM-1:0]        m_err,
  output logic [NS-1:0]        s_req,
  output logic [NS-1:0]        s_we,
  output logic [NS*(DW/8)-1:0] s_be,
  output logic [NS*AW-1:0]     s_addr,
  output logic [NS*DW-1:0]     s_wdata,
  input  logic [NS-1:0]        s_gnt,
  input  logic [NS-1:0]        s_rvalid,
  input  logic [NS*DW-1:0]     s_rdata,
  input  logic [NS-1:0]        s_err
);
  localparam int BW = DW/8;
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam int CW = $clog2(NM+1);

  logic [NM-1:0]                 pending_q;
  logic [NS-1:0][IW-1:0]         ptr_q;
  logic [NS-1:0][NM-1:0][IW-1:0] fifo_q;
  logic [NS-1:0][CW-1:0]         cnt_q;
  logic                          err_busy_q;
  logic [IW-1:0]                 err_id_q;

  logic [NM-1:0]         hit;
  logic [NM-1:0][SW-1:0] tgt;
  logic [NM-1:0]         elig;
  logic [NS-1:0]         pop;
  logic [NS-1:0]         win_vld;
  logic [NS-1:0][IW-1:0] win_id;
  logic                  err_win_vld;
  logic [IW-1:0]         err_win;

  // Lowest matching slave index wins, so scan downwards and let later hits override.
  always_comb begin
    hit = '0;
    tgt = '0;
    for (int i = 0; i < NM; i++) begin
      for (int j = NS-1; j >= 0; j--) begin
        if ((m_addr[i*AW +: AW] & SLV_MASK[j*AW +: AW]) == SLV_BASE[j*AW +: AW]) begin
          hit[i] = 1'b1;
          tgt[i] = SW'(j);
        end
      end
    end
  end

  always_comb begin
    m_rvalid = '0;
    m_rdata  = '0;
    m_err    = '0;
    pop      = '0;
    for (int j = 0; j < NS; j++) pop[j] = s_rvalid[j] && (cnt_q[j] != '0);
    for (int i = 0; i < NM; i++) begin
      for (int j = 0; j < NS; j++) begin
        if (pop[j] && fifo_q[j][0] == IW'(i)) begin
          m_rvalid[i]         = 1'b1;
          m_rdata[i*DW +: DW] = s_rdata[j*DW +: DW];
          m_err[i]            = s_err[j];
        end
      end
      if (err_busy_q && err_id_q == IW'(i)) begin
        m_rvalid[i]         = 1'b1;
        m_err[i]            = 1'b1;
        m_rdata[i*DW +: DW] = '0;
      end
    end
  end

  // A response arriving this cycle frees the master for a new grant in the same cycle.
  assign elig = m_req & (~pending_q | m_rvalid);

  always_comb begin
    win_vld     = '0;
    win_id      = '0;
    s_req       = '0;
    s_we        = '0;
    s_be        = '0;
    s_addr      = '0;
    s_wdata     = '0;
    m_gnt       = '0;
    err_win_vld = 1'b0;
    err_win     = '0;
    for (int j = 0; j < NS; j++) begin
      for (int o = 0; o < NM; o++) begin
        for (int i = 0; i < NM; i++) begin
          if (!win_vld[j] && elig[i] && hit[i] && tgt[i] == SW'(j) &&
              ((int'(ptr_q[j]) + o) % NM) == i) begin
            win_vld[j]          = 1'b1;
            win_id[j]           = IW'(i);
            s_req[j]            = 1'b1;
            s_we[j]             = m_we[i];
            s_be[j*BW +: BW]    = m_be[i*BW +: BW];
            s_addr[j*AW +: AW]  = m_addr[i*AW +: AW];
            s_wdata[j*DW +: DW] = m_wdata[i*DW +: DW];
            m_gnt[i]            = s_gnt[j];
          end
        end
      end
    end
    for (int i = 0; i < NM; i++) begin
      if (!err_win_vld && elig[i] && !hit[i]) begin
        err_win_vld = 1'b1;
        err_win     = IW'(i);
        m_gnt[i]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending_q  <= '0;
      ptr_q      <= '0;
      fifo_q     <= '0;
      cnt_q      <= '0;
      err_busy_q <= 1'b0;
      err_id_q   <= '0;
    end else begin
      pending_q  <= (pending_q & ~m_rvalid) | m_gnt;
      err_busy_q <= err_win_vld;
      err_id_q   <= err_win;
      for (int j = 0; j < NS; j++) begin
        if (pop[j]) begin
          for (int e = 0; e < NM-1; e++) fifo_q[j][e] <= fifo_q[j][e+1];
        end
        // Push lands behind the surviving entries, so a same-cycle pop at full is safe.
        if (win_vld[j] && s_gnt[j]) begin
          ptr_q[j] <= IW'((int'(win_id[j]) + 1) % NM);
          for (int e = 0; e < NM; e++) begin
            if (e == int'(cnt_q[j]) - int'(pop[j])) fifo_q[j][e] <= win_id[j];
          end
        end
        cnt_q[j] <= cnt_q[j] + CW'(win_vld[j] && s_gnt[j]) - CW'(pop[j]);
      end
    end
  end
endmodule

// File: tb/tb_zeroriscy_xbar_nxm.sv
// tb/tb_zeroriscy_xbar_nxm.sv - directed and randomized check of the crossbar against a queue-based model
`timescale 1ns/1ps
module tb_zeroriscy_xbar_nxm;
  localparam int NM = 2;
  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW/8;
  localparam logic [NS*AW-1:0] BASE = {32'h0000_0000, 32'h8010_0000, 32'h8000_0000};
  localparam logic [NS*AW-1:0] MASK = {32'hFFF0_0000, 32'hFFF0_0000, 32'hFFF0_0000};

  logic clk = 1'b0;
  logic resetn;
  logic [NM-1:0] m_req, m_we, m_gnt, m_rvalid, m_err;
  logic [NM*BW-1:0] m_be;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata, m_rdata;
  logic [NS-1:0] s_req, s_we, s_gnt, s_rvalid, s_err;
  logic [NS*BW-1:0] s_be;
  logic [NS*AW-1:0] s_addr;
  logic [NS*DW-1:0] s_wdata, s_rdata;

  always #5 clk = ~clk;

  zeroriscy_xbar_nxm #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .SLV_BASE(BASE), .SLV_MASK(MASK)) dut (
    .clk(clk), .resetn(resetn),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int decode(logic [AW-1:0] a);
    for (int j = 0; j < NS; j++)
      if ((a & MASK[j*AW +: AW]) == BASE[j*AW +: AW]) return j;
    return -1;
  endfunction

  // Model state: who owes whom a response, and whose turn it is at each slave.
  int  ptr_m [NS];
  bit  pend_m [NM];
  int  idq [NS][$];
  bit  errb_m;
  int  errid_m;
  bit  chk_en = 1'b0;

  logic [NM-1:0] gnt_seen;
  logic [NS-1:0] acc_seen, rv_seen;

  logic [NM-1:0] e_gnt, e_rv, e_err;
  logic [NM*DW-1:0] e_rd;
  logic [NS-1:0] e_req, e_we;
  logic [NS*BW-1:0] e_be;
  logic [NS*AW-1:0] e_addr;
  logic [NS*DW-1:0] e_wd;
  bit elig [NM];
  int tg [NM];
  int win [NS];
  int eg, k, c, w;

  always @(negedge clk) begin
    e_gnt = '0; e_rv = '0; e_err = '0; e_rd = '0;
    e_req = '0; e_we = '0; e_be = '0; e_addr = '0; e_wd = '0;
    eg = -1;
    for (int j = 0; j < NS; j++) begin
      win[j] = -1;
      if (s_rvalid[j] && idq[j].size() > 0) begin
        k = idq[j][0];
        e_rv[k] = 1'b1;
        e_rd[k*DW +: DW] = s_rdata[j*DW +: DW];
        e_err[k] = s_err[j];
      end
    end
    if (errb_m) begin
      e_rv[errid_m] = 1'b1;
      e_err[errid_m] = 1'b1;
    end
    for (int i = 0; i < NM; i++) begin
      elig[i] = m_req[i] && (!pend_m[i] || e_rv[i]);
      tg[i] = decode(m_addr[i*AW +: AW]);
    end
    for (int j = 0; j < NS; j++) begin
      for (int o = 0; o < NM; o++) begin
        c = (ptr_m[j] + o) % NM;
        if (win[j] < 0 && elig[c] && tg[c] == j) win[j] = c;
      end
      if (win[j] >= 0) begin
        w = win[j];
        e_req[j] = 1'b1;
        e_we[j] = m_we[w];
        e_be[j*BW +: BW] = m_be[w*BW +: BW];
        e_addr[j*AW +: AW] = m_addr[w*AW +: AW];
        e_wd[j*DW +: DW] = m_wdata[w*DW +: DW];
        e_gnt[w] = s_gnt[j];
      end
    end
    for (int i = 0; i < NM; i++) begin
      if (eg < 0 && elig[i] && tg[i] < 0) begin
        eg = i;
        e_gnt[i] = 1'b1;
      end
    end
    if (chk_en) begin
      chk("m_gnt", m_gnt, e_gnt);
      chk("m_rvalid", m_rvalid, e_rv);
      chk("m_err", m_err, e_err);
      chk("m_rdata", m_rdata, e_rd);
      chk("s_req", s_req, e_req);
      chk("s_we", s_we, e_we);
      chk("s_be", s_be, e_be);
      chk("s_addr", s_addr, e_addr);
      chk("s_wdata", s_wdata, e_wd);
    end
    if (!resetn) begin
      for (int j = 0; j < NS; j++) begin
        ptr_m[j] = 0;
        idq[j].delete();
      end
      for (int i = 0; i < NM; i++) pend_m[i] = 1'b0;
      errb_m = 1'b0;
    end else begin
      for (int j = 0; j < NS; j++)
        if (s_rvalid[j] && idq[j].size() > 0) void'(idq[j].pop_front());
      for (int i = 0; i < NM; i++)
        if (e_rv[i]) pend_m[i] = 1'b0;
      for (int j = 0; j < NS; j++) begin
        if (win[j] >= 0 && s_gnt[j]) begin
          idq[j].push_back(win[j]);
          ptr_m[j] = (win[j] + 1) % NM;
          pend_m[win[j]] = 1'b1;
        end
      end
      errb_m = (eg >= 0);
      if (eg >= 0) begin
        errid_m = eg;
        pend_m[eg] = 1'b1;
      end
    end
    gnt_seen = m_gnt;
    acc_seen = s_req & s_gnt;
    rv_seen  = s_rvalid;
  end

  task automatic idle();
    m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
    s_gnt = '0; s_rvalid = '0; s_rdata = '0; s_err = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [DW-1:0] sqd [NS][$];
  bit            sqe [NS][$];
  logic [AW-1:0] a;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    chk_en = 1'b1;
    smp();
    chk("rst_gnt", m_gnt, 2'b00);
    chk("rst_rvalid", m_rvalid, 2'b00);
    chk("rst_sreq", s_req, 3'b000);
    chk("rst_rdata", m_rdata, 64'h0);

    // single read through slave 0
    nxt(); m_req = 2'b01; m_addr[31:0] = 32'h8000_0010; s_gnt = 3'b001;
    smp(); chk("rd_gnt", m_gnt, 2'b01); chk("rd_saddr", s_addr[31:0], 32'h8000_0010);
    nxt(); idle(); s_rvalid = 3'b001; s_rdata[31:0] = 32'hDEAD_BEEF;
    smp(); chk("rd_rvalid", m_rvalid, 2'b01); chk("rd_rdata", m_rdata[31:0], 32'hDEAD_BEEF);

    // both masters on slave 1: grants alternate, responses follow grant order
    nxt(); m_req = 2'b11; m_addr = {32'h8010_0008, 32'h8010_0004}; s_gnt = 3'b010;
    smp(); chk("rr_gnt0", m_gnt, 2'b01);
    nxt(); s_rvalid = 3'b010; s_rdata[63:32] = 32'h1111_0000;
    smp(); chk("rr_gnt1", m_gnt, 2'b10); chk("rr_rv1", m_rvalid, 2'b01); chk("rr_rd1", m_rdata[31:0], 32'h1111_0000);
    nxt(); s_rdata[63:32] = 32'h1111_0001;
    smp(); chk("rr_gnt2", m_gnt, 2'b01); chk("rr_rv2", m_rvalid, 2'b10); chk("rr_rd2", m_rdata[63:32], 32'h1111_0001);
    nxt(); s_rdata[63:32] = 32'h1111_0002;
    smp(); chk("rr_gnt3", m_gnt, 2'b10); chk("rr_rv3", m_rvalid, 2'b01);
    nxt(); m_req = 2'b00; s_gnt = 3'b000; s_rdata[63:32] = 32'h1111_0003;
    smp(); chk("rr_rv4", m_rvalid, 2'b10); chk("rr_rd4", m_rdata[63:32], 32'h1111_0003);

    // stalled slave 2 keeps the request waiting
    nxt(); idle(); m_req = 2'b10; m_addr[63:32] = 32'h0000_1000;
    for (int n = 0; n < 3; n++) begin
      smp(); chk("stall_gnt", m_gnt, 2'b00); chk("stall_sreq", s_req, 3'b100);
      nxt();
    end
    s_gnt = 3'b100;
    smp(); chk("stall_release_gnt", m_gnt, 2'b10);
    nxt(); idle(); s_rvalid = 3'b100;
    smp(); chk("stall_rv", m_rvalid, 2'b10);

    // unmapped write goes to the error responder
    nxt(); idle(); m_req = 2'b01; m_we = 2'b01; m_be = 8'h0F; m_addr[31:0] = 32'h4000_0000;
    smp(); chk("unm_gnt", m_gnt, 2'b01); chk("unm_sreq", s_req, 3'b000);
    nxt(); idle();
    smp(); chk("unm_rv", m_rvalid, 2'b01); chk("unm_err", m_err, 2'b01); chk("unm_rdata", m_rdata, 64'h0);

    // second request waits for the first response, then is granted in that cycle
    nxt(); idle(); m_req = 2'b01; m_addr[31:0] = 32'h8000_0020; s_gnt = 3'b001;
    smp(); chk("pend_gnt0", m_gnt, 2'b01);
    nxt(); m_addr[31:0] = 32'h8000_0024;
    smp(); chk("pend_block1", m_gnt, 2'b00);
    nxt();
    smp(); chk("pend_block2", m_gnt, 2'b00);
    nxt(); s_rvalid = 3'b001; s_rdata[31:0] = 32'h5555_AAAA;
    smp(); chk("pend_gnt_rv", m_gnt, 2'b01); chk("pend_rv", m_rvalid, 2'b01);
    nxt(); idle(); s_rvalid = 3'b001; s_rdata[31:0] = 32'h5555_BBBB;
    smp(); chk("pend_rv2", m_rvalid, 2'b01); chk("pend_rd2", m_rdata[31:0], 32'h5555_BBBB);

    // reset with two IDs queued at slave 0
    nxt(); idle(); m_req = 2'b11; m_addr = {32'h8000_0100, 32'h8000_0000}; s_gnt = 3'b001;
    smp(); chk("rq_gnt_m1", m_gnt, 2'b10);
    nxt();
    smp(); chk("rq_gnt_m0", m_gnt, 2'b01);
    nxt(); idle(); resetn = 1'b0;
    smp();
    nxt(); resetn = 1'b1; s_rvalid = 3'b001; s_rdata[31:0] = 32'h1234_5678;
    smp(); chk("late_rv", m_rvalid, 2'b00); chk("late_rdata", m_rdata, 64'h0);
    chk("late_gnt", m_gnt, 2'b00); chk("late_sreq", s_req, 3'b000);
    nxt(); idle();

    // randomized traffic with in-order bench slaves
    for (int cyc = 0; cyc < 3000; cyc++) begin
      nxt();
      for (int i = 0; i < NM; i++) begin
        if (m_req[i] && gnt_seen[i]) m_req[i] = 1'b0;
        if (!m_req[i] && $urandom_range(0, 99) < 60) begin
          case ($urandom_range(0, 3))
            0: a = 32'h8000_0000 | ($urandom & 32'h000F_FFFC);
            1: a = 32'h8010_0000 | ($urandom & 32'h000F_FFFC);
            2: a = 32'h0000_0000 | ($urandom & 32'h000F_FFFC);
            default: a = 32'h4000_0000 | ($urandom & 32'h000F_FFFC);
          endcase
          m_addr[i*AW +: AW] = a;
          m_we[i] = 1'($urandom_range(0, 1));
          m_be[i*BW +: BW] = BW'($urandom);
          m_wdata[i*DW +: DW] = $urandom;
          m_req[i] = 1'b1;
        end
      end
      for (int j = 0; j < NS; j++) begin
        if (rv_seen[j] && sqd[j].size() > 0) begin
          void'(sqd[j].pop_front());
          void'(sqe[j].pop_front());
        end
        if (acc_seen[j]) begin
          sqd[j].push_back($urandom);
          sqe[j].push_back($urandom_range(0, 7) == 0);
        end
        s_gnt[j] = ($urandom_range(0, 99) < 65);
        if (sqd[j].size() > 0 && $urandom_range(0, 99) < 55) begin
          s_rvalid[j] = 1'b1;
          s_rdata[j*DW +: DW] = sqd[j][0];
          s_err[j] = sqe[j][0];
        end else begin
          s_rvalid[j] = 1'b0;
          s_rdata[j*DW +: DW] = $urandom;
          s_err[j] = 1'($urandom_range(0, 1));
        end
      end
    end
    nxt(); idle();
    smp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
